// File: rtl/rr_logging_bus_pack2unpack.sv
// rtl/rr_logging_bus_pack2unpack.sv - logb record unpacker with per-channel valid/ready
// Scatters a packed record (present channels concatenated, ch0 at LSB) onto fixed slots.
module rr_logging_bus_pack2unpack #(
   parameter int CH_CNT        = 4,
   parameter int CH_WIDTH_BITS = 16,
   parameter logic [CH_CNT*CH_WIDTH_BITS-1:0] CHANNEL_WIDTHS = {16'd8, 16'd32, 16'd16, 16'd8},
   parameter int FULL_WIDTH    = 64,
   parameter int OFFSET_WIDTH  = $clog2(FULL_WIDTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [CH_CNT-1:0]       in_mask,
   input  logic [FULL_WIDTH-1:0]   in_data,
   input  logic [OFFSET_WIDTH-1:0] in_len,
   output logic                    in_ready,
   output logic [CH_CNT-1:0]       out_valid,
   output logic [FULL_WIDTH-1:0]   out_data,
   input  logic [CH_CNT-1:0]       out_ready,
   output logic                    len_err,
   output logic [31:0]             rec_cnt
);

   function automatic int ch_w(input int i);
      return int'(CHANNEL_WIDTHS[i*CH_WIDTH_BITS +: CH_WIDTH_BITS]);
   endfunction

   function automatic int ch_off(input int i);
      int s;
      s = 0;
      for (int j = 0; j < i; j++) s += ch_w(j);
      return s;
   endfunction

   function automatic logic [FULL_WIDTH-1:0] lane_mask(input int i);
      return ~({FULL_WIDTH{1'b1}} << ch_w(i));
   endfunction

   logic [CH_CNT-1:0]       pend;
   logic [CH_CNT-1:0]       fire;
   logic                    accept;
   logic [OFFSET_WIDTH-1:0] dyn_off;
   logic [FULL_WIDTH-1:0]   unpacked;

   assign out_valid = pend;
   assign fire      = pend & out_ready;
   assign in_ready  = !rst && ((pend & ~fire) == '0);
   assign accept    = in_valid && in_ready;

   // dyn_off walks the packed stream; after the loop it equals the expected record length
   always_comb begin
      dyn_off  = '0;
      unpacked = '0;
      for (int i = 0; i < CH_CNT; i++) begin
         if (in_mask[i]) begin
            unpacked = unpacked | (((in_data >> dyn_off) & lane_mask(i)) << ch_off(i));
            dyn_off  = dyn_off + OFFSET_WIDTH'(ch_w(i));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend     <= '0;
         out_data <= '0;
         len_err  <= 1'b0;
         rec_cnt  <= '0;
      end else if (accept) begin
         pend    <= in_mask;
         rec_cnt <= rec_cnt + 32'd1;
         if (in_mask != '0) out_data <= unpacked;
         if (in_len != dyn_off) len_err <= 1'b1;
      end else begin
         pend <= pend & ~fire;
      end
   end

   a_in_stable: assert property (@(posedge clk)
      (!rst && in_valid && !in_ready) |=>
         (!in_valid || ($stable(in_mask) && $stable(in_data) && $stable(in_len))));

   a_valid_rise: assert property (@(posedge clk) disable iff (rst)
      ((out_valid & ~$past(out_valid)) != '0) |-> $past(accept));

endmodule

// File: tb/tb_rr_logging_bus_pack2unpack.sv
// tb/tb_rr_logging_bus_pack2unpack.sv - randomized + directed bench against a record-level model
// Model keeps per-channel slot values and a pending set; every cycle all outputs are compared.
module tb_rr_logging_bus_pack2unpack;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [3:0]  in_mask;
   logic [63:0] in_data;
   logic [6:0]  in_len;
   logic        in_ready;
   logic [3:0]  out_valid;
   logic [63:0] out_data;
   logic [3:0]  out_ready;
   logic        len_err;
   logic [31:0] rec_cnt;

   always #5 clk = ~clk;

   rr_logging_bus_pack2unpack dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_mask(in_mask), .in_data(in_data),
      .in_len(in_len), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .len_err(len_err), .rec_cnt(rec_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int cw[4] = '{8, 16, 32, 8};
   int co[4] = '{0, 8, 24, 56};

   logic [3:0]      m_pend;
   longint unsigned m_slot[4];
   bit              m_err;
   int unsigned     m_cnt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int exp_len(input logic [3:0] m);
      int s;
      s = 0;
      for (int i = 0; i < 4; i++) if (m[i]) s += cw[i];
      return s;
   endfunction

   function automatic logic [63:0] m_bus();
      logic [63:0] b;
      b = '0;
      for (int i = 0; i < 4; i++) b = b | (64'(m_slot[i]) << co[i]);
      return b;
   endfunction

   task automatic model_reset();
      m_pend = '0;
      m_err  = 1'b0;
      m_cnt  = 0;
      for (int i = 0; i < 4; i++) m_slot[i] = 0;
   endtask

   // One clock: drive at negedge, compare against model, advance model, step to next negedge
   task automatic cycle(input bit r, input bit v, input logic [3:0] m, input logic [63:0] d,
                        input logic [6:0] l, input logic [3:0] rdy, output bit rdy_seen);
      bit exp_rdy;
      int pos;
      rst = r; in_valid = v; in_mask = m; in_data = d; in_len = l; out_ready = rdy;
      #1;
      exp_rdy = !r;
      for (int i = 0; i < 4; i++) if (m_pend[i] && !rdy[i]) exp_rdy = 1'b0;
      check("in_ready",  64'(in_ready),  64'(exp_rdy));
      check("out_valid", 64'(out_valid), 64'(m_pend));
      check("out_data",  out_data,       m_bus());
      check("len_err",   64'(len_err),   64'(m_err));
      check("rec_cnt",   64'(rec_cnt),   64'(m_cnt));
      rdy_seen = in_ready;
      if (r) begin
         model_reset();
      end else if (v && exp_rdy) begin
         m_pend = m;
         m_cnt  = m_cnt + 1;
         if (m != 4'h0) begin
            pos = 0;
            for (int i = 0; i < 4; i++) begin
               if (m[i]) begin
                  m_slot[i] = (d >> pos) & ((64'd1 << cw[i]) - 64'd1);
                  pos += cw[i];
               end else begin
                  m_slot[i] = 0;
               end
            end
         end
         if (int'(l) != exp_len(m)) m_err = 1'b1;
      end else begin
         m_pend = m_pend & ~rdy;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      bit          s;
      bit          have;
      bit          r;
      bit          rv;
      logic [3:0]  rm;
      logic [63:0] rd;
      logic [6:0]  rl;

      rst = 1'b1; in_valid = 1'b0; in_mask = '0; in_data = '0; in_len = '0; out_ready = '0;
      model_reset();
      @(posedge clk);
      @(negedge clk);

      cycle(1, 0, 4'h0, 64'h0, 7'd0, 4'h0, s);
      check("reset_in_ready", 64'(s), 64'd0);
      check("reset_rec_cnt", 64'(rec_cnt), 64'd0);

      // full record
      cycle(0, 1, 4'hF, 64'hDDCCCCCCCCBBBBAA, 7'd64, 4'hF, s);
      check("full_accept", 64'(s), 64'd1);
      check("full_valid", 64'(out_valid), 64'hF);
      check("full_data", out_data, 64'hDDCCCCCCCCBBBBAA);
      check("full_len_err", 64'(len_err), 64'd0);
      check("full_rec_cnt", 64'(rec_cnt), 64'd1);

      // sparse record loads as the full one drains; upper junk bits ignored
      cycle(0, 1, 4'b1010, 64'hFFFFFFFFFFDDBBBB, 7'd24, 4'hF, s);
      check("sparse_accept", 64'(s), 64'd1);
      check("sparse_valid", 64'(out_valid), 64'hA);
      check("sparse_data", out_data, 64'hDD00000000BBBB00);
      check("sparse_rec_cnt", 64'(rec_cnt), 64'd2);

      // backpressure on ch1, ch3 drains first
      for (int k = 0; k < 3; k++) begin
         cycle(0, 1, 4'b0001, 64'h5A, 7'd8, 4'b1000, s);
         check("bp_blocked", 64'(s), 64'd0);
         check("bp_valid", 64'(out_valid), 64'h2);
      end
      cycle(0, 1, 4'b0001, 64'h5A, 7'd8, 4'b1010, s);
      check("bp_release", 64'(s), 64'd1);
      check("bp_valid2", 64'(out_valid), 64'h1);
      check("bp_data", out_data, 64'h5A);
      check("bp_rec_cnt", 64'(rec_cnt), 64'd3);

      // length error is sticky, record still unpacked
      cycle(0, 1, 4'b0001, 64'hABCD00000000005A, 7'd16, 4'b0001, s);
      check("lerr_set", 64'(len_err), 64'd1);
      check("lerr_data", out_data, 64'h5A);
      cycle(0, 1, 4'hF, 64'h1122334455667788, 7'd64, 4'h1, s);
      check("lerr_sticky", 64'(len_err), 64'd1);
      check("lerr_rec_cnt", 64'(rec_cnt), 64'd5);

      // empty records: counted, no valid, data held
      cycle(0, 1, 4'h0, 64'h0, 7'd0, 4'hF, s);
      check("empty_accept", 64'(s), 64'd1);
      check("empty_valid", 64'(out_valid), 64'h0);
      check("empty_data_held", out_data, 64'h1122334455667788);
      for (int k = 0; k < 3; k++) begin
         cycle(0, 1, 4'h0, 64'h0, 7'd0, 4'h0, s);
         check("empty_b2b", 64'(s), 64'd1);
         check("empty_rec_cnt", 64'(rec_cnt), 64'(7 + k));
      end

      // reset while ch2 is held
      cycle(0, 1, 4'b0100, 64'h00000000CAFEF00D, 7'd32, 4'h0, s);
      check("mid_data", out_data, 64'h00CAFEF00D000000);
      cycle(0, 0, 4'h0, 64'h0, 7'd0, 4'h0, s);
      check("mid_held", 64'(out_valid), 64'h4);
      cycle(1, 0, 4'h0, 64'h0, 7'd0, 4'h0, s);
      check("mid_rst_ready", 64'(s), 64'd0);
      check("mid_valid", 64'(out_valid), 64'h0);
      check("mid_data0", out_data, 64'h0);
      check("mid_rec_cnt", 64'(rec_cnt), 64'd0);
      cycle(0, 0, 4'h0, 64'h0, 7'd0, 4'h0, s);
      check("mid_after_ready", 64'(s), 64'd1);

      // randomized traffic; a presented record is held until accepted
      have = 1'b0;
      rm = '0; rd = '0; rl = '0;
      for (int k = 0; k < 3000; k++) begin
         r = ($urandom_range(0, 199) == 0);
         if (!have) begin
            rm = 4'($urandom);
            rd = {$urandom(), $urandom()};
            rl = 7'(exp_len(rm));
            if ($urandom_range(0, 39) == 0) rl = 7'($urandom_range(0, 64));
            have = 1'b1;
         end
         rv = ($urandom_range(0, 3) != 0);
         cycle(r, rv, rm, rd, rl, 4'($urandom), s);
         if (rv && s) have = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
